// File: rtl/data_mem_responder.sv
// Data-memory slave for the multicycle control unit: accepts one load/store command,
// services it after WAIT_CYC wait states and returns a single-cycle completion pulse.
module data_mem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic              LB,
  input  logic              ExtOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a command is accepted on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a one-cycle pulse with no backpressure.

  localparam int         DEPTH   = 2 ** (ADDR_W - 1);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                rd_q, wr_q, lb_q, ext_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-2:0]   word_idx;
  logic [DATA_W-1:0]   rd_word;
  logic [7:0]          rd_byte;
  logic                cmd_err;
  logic [DATA_W-1:0]   rd_result;
  logic [DATA_W-1:0]   wr_word;
  logic                mem_we;

  assign word_idx = addr_q[ADDR_W-1:1];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = addr_q[0] ? rd_word[15:8] : rd_word[7:0];

  // Exactly one of MemRd/MemWr must be set, and word accesses must be halfword aligned.
  assign cmd_err  = (rd_q == wr_q) | (~lb_q & addr_q[0]);
  assign mem_we   = (state_q == ST_ACCESS) & wr_q & ~cmd_err & rst_n;

  always_comb begin
    rd_result = '0;
    if (!cmd_err && rd_q) begin
      if (lb_q) rd_result = {{(DATA_W-8){ext_q & rd_byte[7]}}, rd_byte};
      else      rd_result = rd_word;
    end
  end

  // Byte stores rewrite only the addressed lane of the current word.
  always_comb begin
    wr_word = wdata_q;
    if (lb_q) begin
      wr_word = rd_word;
      if (addr_q[0]) wr_word[15:8] = wdata_q[7:0];
      else           wr_word[7:0]  = wdata_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      lb_q        <= 1'b0;
      ext_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            rd_q    <= MemRd;
            wr_q    <= MemWr;
            lb_q    <= LB;
            ext_q   <= ExtOp;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= WAIT_LD;
            state_q <= (WAIT_LD == 4'd0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= cmd_err;
          rsp_rdata_q <= rd_result;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule
